// File: rtl/efuse_access_sequencer_if.sv
// Request/response and eFuse state-machine signals for efuse_access_sequencer.
// The sequencer takes the slave modport; the requesters and state machine take the master modport.
interface efuse_access_sequencer_if;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned KEY_W   = 8;
  localparam int unsigned TCKHP_W = 4;

  logic               al_req;
  logic               al_ack;
  logic               sc_req;
  logic               sc_cmd;
  logic [DATA_W-1:0]  sc_wdata;
  logic [KEY_W-1:0]   sc_key;
  logic [TCKHP_W-1:0] sc_tckhp;
  logic               sc_ack;
  logic               busy;
  logic [DATA_W-1:0]  rdata;
  logic               rdata_valid;
  logic               err_key;
  logic               err_timeout;
  logic [1:0]         sm_mode;
  logic               sm_start;
  logic [DATA_W-1:0]  sm_prog;
  logic [TCKHP_W-1:0] sm_tckhp;
  logic               sm_csb;
  logic               sm_sw_short;
  logic [DATA_W-1:0]  efuse_q;

  modport master (
    output al_req, sc_req, sc_cmd, sc_wdata, sc_key, sc_tckhp,
           sm_csb, sm_sw_short, efuse_q,
    input  al_ack, sc_ack, busy, rdata, rdata_valid, err_key, err_timeout,
           sm_mode, sm_start, sm_prog, sm_tckhp
  );

  modport slave (
    input  al_req, sc_req, sc_cmd, sc_wdata, sc_key, sc_tckhp,
           sm_csb, sm_sw_short, efuse_q,
    output al_ack, sc_ack, busy, rdata, rdata_valid, err_key, err_timeout,
           sm_mode, sm_start, sm_prog, sm_tckhp
  );
endinterface

// File: rtl/efuse_access_sequencer.sv
// Arbitrates autoload and slow-control requests onto the shared eFuse control
// state machine, sequencing its mode/start handshake and capturing read data.
module efuse_access_sequencer #(
  parameter logic [7:0]  UNLOCK_KEY = 8'hA5,
  parameter int unsigned READ_HOLD  = 8,
  parameter logic [11:0] TIMEOUT    = 12'd4000
) (
  input  logic                   clk,
  input  logic                   rst,
  efuse_access_sequencer_if.slave bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TCKHP_W = 4;
  localparam int unsigned HOLD_W  = 8;
  localparam int unsigned WDOG_W  = 12;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READ_HOLD - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = TIMEOUT - WDOG_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_WR_REQ, S_WR_RUN, S_RD_REQ, S_RD_HOLD, S_RD_REL, S_DONE
  } state_t;

  state_t               r_state,        w_state_nxt;
  logic                 r_gnt_al,       w_gnt_al_nxt;
  logic                 r_cmd_wr,       w_cmd_wr_nxt;
  logic                 r_key_ok,       w_key_ok_nxt;
  logic                 r_seen_low,     w_seen_low_nxt;
  logic [HOLD_W-1:0]    r_hold_cnt,     w_hold_cnt_nxt;
  logic [WDOG_W-1:0]    r_wdog,         w_wdog_nxt;
  logic                 r_al_ack,       w_al_ack_nxt;
  logic                 r_sc_ack,       w_sc_ack_nxt;
  logic                 r_busy,         w_busy_nxt;
  logic [DATA_W-1:0]    r_rdata,        w_rdata_nxt;
  logic                 r_rdata_valid,  w_rdata_valid_nxt;
  logic                 r_err_key,      w_err_key_nxt;
  logic                 r_err_timeout,  w_err_timeout_nxt;
  logic [1:0]           r_sm_mode,      w_sm_mode_nxt;
  logic                 r_sm_start,     w_sm_start_nxt;
  logic [DATA_W-1:0]    r_sm_prog,      w_sm_prog_nxt;
  logic [TCKHP_W-1:0]   r_sm_tckhp,     w_sm_tckhp_nxt;
  logic                 w_timeout;
  logic                 w_wait_state;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_gnt_al      <= 1'b0;
      r_cmd_wr      <= 1'b0;
      r_key_ok      <= 1'b0;
      r_seen_low    <= 1'b0;
      r_hold_cnt    <= '0;
      r_wdog        <= '0;
      r_al_ack      <= 1'b0;
      r_sc_ack      <= 1'b0;
      r_busy        <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err_key     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_sm_mode     <= 2'b00;
      r_sm_start    <= 1'b0;
      r_sm_prog     <= '0;
      r_sm_tckhp    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt_al      <= w_gnt_al_nxt;
      r_cmd_wr      <= w_cmd_wr_nxt;
      r_key_ok      <= w_key_ok_nxt;
      r_seen_low    <= w_seen_low_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_wdog        <= w_wdog_nxt;
      r_al_ack      <= w_al_ack_nxt;
      r_sc_ack      <= w_sc_ack_nxt;
      r_busy        <= w_busy_nxt;
      r_rdata       <= w_rdata_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      r_err_key     <= w_err_key_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_sm_mode     <= w_sm_mode_nxt;
      r_sm_start    <= w_sm_start_nxt;
      r_sm_prog     <= w_sm_prog_nxt;
      r_sm_tckhp    <= w_sm_tckhp_nxt;
    end
  end

  // Next state; outputs are derived from the state being entered so they line up with it
  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_al_nxt      = r_gnt_al;
    w_cmd_wr_nxt      = r_cmd_wr;
    w_key_ok_nxt      = r_key_ok;
    w_seen_low_nxt    = r_seen_low;
    w_rdata_nxt       = r_rdata;
    w_rdata_valid_nxt = r_rdata_valid;
    w_err_key_nxt     = r_err_key;
    w_err_timeout_nxt = r_err_timeout;
    w_sm_prog_nxt     = r_sm_prog;
    w_sm_tckhp_nxt    = r_sm_tckhp;
    w_timeout         = (r_wdog == WDOG_LAST);

    case (r_state)
      S_IDLE: begin
        if (bus.sm_csb && bus.sm_sw_short && (bus.al_req || bus.sc_req)) begin
          w_state_nxt       = S_GRANT;
          w_gnt_al_nxt      = bus.al_req;
          w_err_key_nxt     = 1'b0;
          w_err_timeout_nxt = 1'b0;
          w_seen_low_nxt    = 1'b0;
          if (bus.al_req) begin
            w_cmd_wr_nxt   = 1'b0;
            w_key_ok_nxt   = 1'b1;
            w_sm_prog_nxt  = '0;
            w_sm_tckhp_nxt = '0;
          end else begin
            w_cmd_wr_nxt   = bus.sc_cmd;
            w_key_ok_nxt   = (bus.sc_key == UNLOCK_KEY);
            w_sm_prog_nxt  = bus.sc_wdata;
            w_sm_tckhp_nxt = bus.sc_tckhp;
          end
          if (!w_cmd_wr_nxt) w_rdata_valid_nxt = 1'b0;
        end
      end
      S_GRANT: begin
        if (r_cmd_wr && !r_key_ok) begin
          w_state_nxt   = S_DONE;
          w_err_key_nxt = 1'b1;
        end else if (r_cmd_wr) begin
          w_state_nxt = S_WR_REQ;
        end else begin
          w_state_nxt = S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        // The switch may already be closed by the time CSB falls
        if (!bus.sm_sw_short) w_seen_low_nxt = 1'b1;
        if (!bus.sm_csb) begin
          w_state_nxt = S_WR_RUN;
        end else if (w_timeout) begin
          w_state_nxt       = S_DONE;
          w_err_timeout_nxt = 1'b1;
        end
      end
      S_WR_RUN: begin
        if (!bus.sm_sw_short) w_seen_low_nxt = 1'b1;
        if (r_seen_low && bus.sm_csb && bus.sm_sw_short) begin
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_state_nxt       = S_DONE;
          w_err_timeout_nxt = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (!bus.sm_csb) begin
          w_state_nxt = S_RD_HOLD;
        end else if (w_timeout) begin
          w_state_nxt       = S_DONE;
          w_err_timeout_nxt = 1'b1;
        end
      end
      S_RD_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt       = S_RD_REL;
          w_rdata_nxt       = bus.efuse_q;
          w_rdata_valid_nxt = 1'b1;
        end
      end
      S_RD_REL: begin
        if (bus.sm_csb) begin
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_state_nxt       = S_DONE;
          w_err_timeout_nxt = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_wait_state = (r_state == S_WR_REQ) || (r_state == S_WR_RUN) ||
                   (r_state == S_RD_REQ) || (r_state == S_RD_REL);

    if (w_state_nxt != r_state) w_wdog_nxt = '0;
    else if (w_wait_state)      w_wdog_nxt = r_wdog + WDOG_W'(1);
    else                        w_wdog_nxt = '0;

    if ((w_state_nxt == r_state) && (r_state == S_RD_HOLD)) w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
    else                                                    w_hold_cnt_nxt = '0;

    w_busy_nxt   = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_al_ack_nxt = (w_state_nxt == S_DONE) && r_gnt_al;
    w_sc_ack_nxt = (w_state_nxt == S_DONE) && !r_gnt_al;

    w_sm_mode_nxt  = 2'b00;
    w_sm_start_nxt = 1'b0;
    if (w_state_nxt == S_WR_REQ) begin
      w_sm_mode_nxt  = 2'b01;
      w_sm_start_nxt = 1'b1;
    end else if ((w_state_nxt == S_RD_REQ) || (w_state_nxt == S_RD_HOLD)) begin
      w_sm_mode_nxt = 2'b10;
    end
  end

  assign bus.al_ack      = r_al_ack;
  assign bus.sc_ack      = r_sc_ack;
  assign bus.busy        = r_busy;
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.err_key     = r_err_key;
  assign bus.err_timeout = r_err_timeout;
  assign bus.sm_mode     = r_sm_mode;
  assign bus.sm_start    = r_sm_start;
  assign bus.sm_prog     = r_sm_prog;
  assign bus.sm_tckhp    = r_sm_tckhp;

endmodule

// File: tb/tb_efuse_access_sequencer.sv
// Directed bench for efuse_access_sequencer: a behavioural eFuse state machine
// answers the handshake, and a scoreboard checks every ack against queued expectations.
module tb_efuse_access_sequencer;

  typedef struct {
    bit          al;
    logic [31:0] rdata;
    logic        rv;
    logic        ek;
    logic        eto;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  efuse_access_sequencer_if bus ();

  efuse_access_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          m_stuck;
  int          m_st, m_cnt;

  int          t_cycles, t_mode10_low, t_mode10_any, t_mode10_starts, t_prog_bad, t_start_bad;
  bit          t_saw_start, t_saw_mode, t_saw_short_low, t_prog_en;
  logic [31:0] exp_prog;
  logic [3:0]  exp_tckhp;

  // eFuse control state machine model: read = CSB low 3 cycles after mode 10,
  // write = switch closes, CSB falls, programs for 4*TCKHP+2 cycles after start drops.
  always @(negedge clk) begin
    if (!rst) begin
      m_st = 0;
      m_cnt = 0;
      bus.sm_csb = 1'b1;
      bus.sm_sw_short = 1'b1;
    end else begin
      case (m_st)
        0: if (!m_stuck) begin
             if (bus.sm_mode == 2'b10) begin
               m_st = 1; m_cnt = 0;
             end else if (bus.sm_mode == 2'b01 && bus.sm_start) begin
               m_st = 4; m_cnt = 0; bus.sm_sw_short = 1'b0;
             end
           end
        1: begin m_cnt++; if (m_cnt == 3) begin bus.sm_csb = 1'b0; m_st = 2; end end
        2: if (bus.sm_mode == 2'b00) begin m_st = 3; m_cnt = 0; end
        3: begin m_cnt++; if (m_cnt == 2) begin bus.sm_csb = 1'b1; m_st = 0; end end
        4: begin m_cnt++; if (m_cnt == 3) begin bus.sm_csb = 1'b0; m_st = 5; end end
        5: if (!bus.sm_start) begin m_st = 6; m_cnt = 0; end
        6: begin
             m_cnt++;
             if (m_cnt == 4 * int'(bus.sm_tckhp) + 2) begin
               bus.sm_csb = 1'b1; bus.sm_sw_short = 1'b1; m_st = 0;
             end
           end
        default: m_st = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run until every queued expectation has been matched by an ack, observing the handshake
  task automatic service(input int budget);
    logic [1:0] prev_mode;
    logic       prev_start;
    int         spurious;
    exp_t       e;
    t_cycles = 0; t_mode10_low = 0; t_mode10_any = 0; t_mode10_starts = 0;
    t_prog_bad = 0; t_start_bad = 0;
    t_saw_start = 0; t_saw_mode = 0; t_saw_short_low = 0;
    prev_mode = bus.sm_mode;
    prev_start = bus.sm_start;
    while (sb.size() != 0 && t_cycles < budget) begin
      tick();
      t_cycles++;
      if (bus.sm_mode == 2'b10) begin
        t_mode10_any++;
        if (!bus.sm_csb) t_mode10_low++;
        if (prev_mode != 2'b10) t_mode10_starts++;
      end
      if (bus.sm_mode != 2'b00) t_saw_mode = 1;
      if (bus.sm_start) t_saw_start = 1;
      if (!bus.sm_sw_short) t_saw_short_low = 1;
      if (prev_start && !bus.sm_start && bus.sm_csb) t_start_bad++;
      if (t_prog_en && bus.busy && (bus.sm_prog !== exp_prog || bus.sm_tckhp !== exp_tckhp)) t_prog_bad++;
      prev_mode = bus.sm_mode;
      prev_start = bus.sm_start;
      if (bus.al_ack || bus.sc_ack) begin
        e = sb.pop_front();
        chk("ack_al",      32'(bus.al_ack),      32'(e.al));
        chk("ack_sc",      32'(bus.sc_ack),      32'(!e.al));
        chk("rdata",       bus.rdata,            e.rdata);
        chk("rdata_valid", 32'(bus.rdata_valid), 32'(e.rv));
        chk("err_key",     32'(bus.err_key),     32'(e.ek));
        chk("err_timeout", 32'(bus.err_timeout), 32'(e.eto));
        chk("busy_at_ack", 32'(bus.busy),        32'd0);
        if (bus.al_ack) bus.al_req = 1'b0;
        if (bus.sc_ack) bus.sc_req = 1'b0;
      end
    end
    chk("acks_pending", 32'(sb.size()), 32'd0);
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.al_ack || bus.sc_ack) spurious++;
    end
    chk("spurious_ack", 32'(spurious), 32'd0);
  endtask

  initial begin
    int ack_seen;
    int n;
    bit seen;
    rst = 1'b0;
    m_stuck = 1'b0;
    t_prog_en = 1'b0;
    exp_prog = '0;
    exp_tckhp = '0;
    bus.al_req = 1'b0;
    bus.sc_req = 1'b0;
    bus.sc_cmd = 1'b0;
    bus.sc_wdata = '0;
    bus.sc_key = '0;
    bus.sc_tckhp = '0;
    bus.efuse_q = '0;
    repeat (3) tick();
    rst = 1'b1;

    // Idle after reset: nothing moves
    ack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.al_ack || bus.sc_ack) ack_seen++;
    end
    chk("rst_ack",         32'(ack_seen),         32'd0);
    chk("rst_busy",        32'(bus.busy),         32'd0);
    chk("rst_rdata_valid", 32'(bus.rdata_valid),  32'd0);
    chk("rst_err_key",     32'(bus.err_key),      32'd0);
    chk("rst_err_timeout", 32'(bus.err_timeout),  32'd0);
    chk("rst_sm_mode",     32'(bus.sm_mode),      32'd0);
    chk("rst_sm_start",    32'(bus.sm_start),     32'd0);
    chk("rst_rdata",       bus.rdata,             32'd0);
    chk("rst_sm_prog",     bus.sm_prog,           32'd0);
    chk("rst_sm_tckhp",    32'(bus.sm_tckhp),     32'd0);

    // Autoload read
    bus.efuse_q = 32'hDEADBEEF;
    sb.push_back('{al: 1'b1, rdata: 32'hDEADBEEF, rv: 1'b1, ek: 1'b0, eto: 1'b0});
    bus.al_req = 1'b1;
    service(100);
    chk("rd_hold_cycles", 32'(t_mode10_low),    32'd8);
    chk("rd_sequences",   32'(t_mode10_starts), 32'd1);
    chk("rd_csb_at_end",  32'(bus.sm_csb),      32'd1);

    // Keyed write
    bus.sc_cmd = 1'b1;
    bus.sc_wdata = 32'h12345678;
    bus.sc_key = 8'hA5;
    bus.sc_tckhp = 4'd4;
    t_prog_en = 1'b1;
    exp_prog = 32'h12345678;
    exp_tckhp = 4'd4;
    sb.push_back('{al: 1'b0, rdata: 32'hDEADBEEF, rv: 1'b1, ek: 1'b0, eto: 1'b0});
    bus.sc_req = 1'b1;
    service(200);
    t_prog_en = 1'b0;
    chk("wr_prog_stable",   32'(t_prog_bad),      32'd0);
    chk("wr_saw_start",     32'(t_saw_start),     32'd1);
    chk("wr_start_early",   32'(t_start_bad),     32'd0);
    chk("wr_short_low",     32'(t_saw_short_low), 32'd1);
    chk("wr_short_at_end",  32'(bus.sm_sw_short), 32'd1);
    chk("wr_sm_prog_after", bus.sm_prog,          32'h12345678);

    // Write with a wrong key is rejected without touching the state machine
    bus.sc_key = 8'h00;
    bus.sc_wdata = 32'hFFFF0000;
    sb.push_back('{al: 1'b0, rdata: 32'hDEADBEEF, rv: 1'b1, ek: 1'b1, eto: 1'b0});
    bus.sc_req = 1'b1;
    service(20);
    chk("key_ack_latency", 32'(t_cycles),    32'd2);
    chk("key_no_mode",     32'(t_saw_mode),  32'd0);
    chk("key_no_start",    32'(t_saw_start), 32'd0);

    // Simultaneous autoload and slow-control reads: autoload first
    bus.efuse_q = 32'h0BADF00D;
    bus.sc_cmd = 1'b0;
    bus.sc_key = 8'hA5;
    sb.push_back('{al: 1'b1, rdata: 32'h0BADF00D, rv: 1'b1, ek: 1'b0, eto: 1'b0});
    sb.push_back('{al: 1'b0, rdata: 32'h0BADF00D, rv: 1'b1, ek: 1'b0, eto: 1'b0});
    bus.al_req = 1'b1;
    bus.sc_req = 1'b1;
    service(200);
    chk("dual_sequences", 32'(t_mode10_starts), 32'd2);
    chk("dual_hold",      32'(t_mode10_low),    32'd16);

    // CSB never falls: watchdog ends the read
    m_stuck = 1'b1;
    sb.push_back('{al: 1'b1, rdata: 32'h0BADF00D, rv: 1'b0, ek: 1'b0, eto: 1'b1});
    bus.al_req = 1'b1;
    service(4100);
    chk("to_mode10_cycles", 32'(t_mode10_any), 32'd4000);
    chk("to_mode_after",    32'(bus.sm_mode),  32'd0);
    m_stuck = 1'b0;

    // Reset in the middle of a write
    bus.sc_cmd = 1'b1;
    bus.sc_wdata = 32'h12345678;
    bus.sc_key = 8'hA5;
    bus.sc_tckhp = 4'd4;
    bus.sc_req = 1'b1;
    seen = 0;
    n = 0;
    while (!(seen && !bus.sm_start && bus.busy) && n < 100) begin
      tick();
      if (bus.sm_start) seen = 1;
      n++;
    end
    chk("mid_wr_reached", 32'(seen && !bus.sm_start && bus.busy), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_busy",     32'(bus.busy),     32'd0);
    chk("arst_sm_start", 32'(bus.sm_start), 32'd0);
    chk("arst_sm_mode",  32'(bus.sm_mode),  32'd0);
    chk("arst_sm_prog",  bus.sm_prog,       32'd0);
    chk("arst_sm_tckhp", 32'(bus.sm_tckhp), 32'd0);
    chk("arst_rdata",    bus.rdata,         32'd0);
    chk("arst_err_to",   32'(bus.err_timeout), 32'd0);
    bus.sc_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
